// File: rtl/biriscv_decode_queue_if.sv
// Fetch-to-issue handshake bundle for biriscv_decode_queue.
// Signal suffixes are written from the queue's point of view.
interface biriscv_decode_queue_if #(
  parameter int unsigned FETCH_LANES = 2,
  parameter int unsigned ISSUE_LANES = 2,
  parameter int unsigned DEPTH       = 8
);
  localparam int unsigned POP_W = $clog2(ISSUE_LANES + 1);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic                      flush_i;
  logic                      enable_muldiv_i;
  logic [FETCH_LANES-1:0]    fetch_valid_i;
  logic [FETCH_LANES-1:0]    fetch_fault_i;
  logic [32*FETCH_LANES-1:0] fetch_opcode_i;
  logic [31:0]               fetch_pc_i;
  logic                      fetch_accept_o;
  logic [ISSUE_LANES-1:0]    issue_valid_o;
  logic [32*ISSUE_LANES-1:0] issue_opcode_o;
  logic [32*ISSUE_LANES-1:0] issue_pc_o;
  logic [10*ISSUE_LANES-1:0] issue_flags_o;
  logic [POP_W-1:0]          issue_pop_i;
  logic [CNT_W-1:0]          count_o;

  // Fetch/issue side that drives the queue.
  modport master (
    output flush_i, enable_muldiv_i, fetch_valid_i, fetch_fault_i, fetch_opcode_i, fetch_pc_i,
           issue_pop_i,
    input  fetch_accept_o, issue_valid_o, issue_opcode_o, issue_pc_o, issue_flags_o, count_o
  );

  // The decode queue itself.
  modport slave (
    input  flush_i, enable_muldiv_i, fetch_valid_i, fetch_fault_i, fetch_opcode_i, fetch_pc_i,
           issue_pop_i,
    output fetch_accept_o, issue_valid_o, issue_opcode_o, issue_pc_o, issue_flags_o, count_o
  );
endinterface

// File: rtl/biriscv_decode_queue.sv
// Multi-lane decode stage: classifies up to FETCH_LANES instructions per beat, stores them in a
// circular queue of DEPTH entries and exposes the oldest ISSUE_LANES entries to issue.
// Flags: [0]invalid [1]exec [2]lsu [3]branch [4]mul [5]div [6]csr [7]mule [8]rd_valid [9]fault.
module biriscv_decode_queue #(
  parameter int unsigned FETCH_LANES  = 2,
  parameter int unsigned ISSUE_LANES  = 2,
  parameter int unsigned DEPTH        = 8,
  parameter bit          SUPPORT_MULE = 1'b1
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  biriscv_decode_queue_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned POP_W = $clog2(ISSUE_LANES + 1);
  localparam int unsigned CMP_W = (POP_W > CNT_W) ? POP_W : CNT_W;

  localparam int unsigned F_INVALID = 0;
  localparam int unsigned F_EXEC    = 1;
  localparam int unsigned F_LSU     = 2;
  localparam int unsigned F_BRANCH  = 3;
  localparam int unsigned F_MUL     = 4;
  localparam int unsigned F_DIV     = 5;
  localparam int unsigned F_CSR     = 6;
  localparam int unsigned F_MULE    = 7;
  localparam int unsigned F_RD      = 8;
  localparam int unsigned F_FAULT   = 9;

  // A faulting lane is only ever routed to the CSR/exception path.
  localparam logic [9:0] FAULT_FLAGS = 10'h240;

  // Instruction match masks: major opcode, +funct3, +funct7, M-ext group, exact.
  localparam logic [31:0] M_OP  = 32'h0000_007f;
  localparam logic [31:0] M_F3  = 32'h0000_707f;
  localparam logic [31:0] M_F7  = 32'hfe00_707f;
  localparam logic [31:0] M_MD  = 32'hfe00_407f;
  localparam logic [31:0] M_ALL = 32'hffff_ffff;

  logic [31:0]      r_opcode [DEPTH];
  logic [31:0]      r_pc     [DEPTH];
  logic [9:0]       r_flags  [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic             w_accept;
  logic             w_push;
  logic [CNT_W-1:0] w_push_cnt;
  logic [CNT_W-1:0] w_push_add;
  logic [CNT_W-1:0] w_pop_cnt;
  logic [CMP_W-1:0] w_pop_req;
  logic [PTR_W-1:0] w_wr_idx     [FETCH_LANES];
  logic [31:0]      w_lane_pc    [FETCH_LANES];
  logic [9:0]       w_lane_flags [FETCH_LANES];

  function automatic logic inst_is(input logic [31:0] op, input logic [31:0] pat,
                                   input logic [31:0] mask);
    return (op & mask) == pat;
  endfunction

  function automatic logic [9:0] classify(input logic [31:0] op, input logic en_md);
    logic       exec_hit, load_hit, store_hit, jump_hit, bcc_hit;
    logic       mul_hit, div_hit, csr_rw_hit, csr_sys_hit, mule_hit, any_hit;
    logic [9:0] flags;

    exec_hit = inst_is(op, 32'h0000_0013, M_F3)    // addi
             | inst_is(op, 32'h0000_2013, M_F3)    // slti
             | inst_is(op, 32'h0000_3013, M_F3)    // sltiu
             | inst_is(op, 32'h0000_4013, M_F3)    // xori
             | inst_is(op, 32'h0000_6013, M_F3)    // ori
             | inst_is(op, 32'h0000_7013, M_F3)    // andi
             | inst_is(op, 32'h0000_1013, M_F7)    // slli
             | inst_is(op, 32'h0000_5013, M_F7)    // srli
             | inst_is(op, 32'h4000_5013, M_F7)    // srai
             | inst_is(op, 32'h0000_0037, M_OP)    // lui
             | inst_is(op, 32'h0000_0017, M_OP)    // auipc
             | inst_is(op, 32'h0000_0033, M_F7)    // add
             | inst_is(op, 32'h4000_0033, M_F7)    // sub
             | inst_is(op, 32'h0000_1033, M_F7)    // sll
             | inst_is(op, 32'h0000_2033, M_F7)    // slt
             | inst_is(op, 32'h0000_3033, M_F7)    // sltu
             | inst_is(op, 32'h0000_4033, M_F7)    // xor
             | inst_is(op, 32'h0000_5033, M_F7)    // srl
             | inst_is(op, 32'h4000_5033, M_F7)    // sra
             | inst_is(op, 32'h0000_6033, M_F7)    // or
             | inst_is(op, 32'h0000_7033, M_F7);   // and

    load_hit = inst_is(op, 32'h0000_0003, M_F3)    // lb
             | inst_is(op, 32'h0000_1003, M_F3)    // lh
             | inst_is(op, 32'h0000_2003, M_F3)    // lw
             | inst_is(op, 32'h0000_4003, M_F3)    // lbu
             | inst_is(op, 32'h0000_5003, M_F3)    // lhu
             | inst_is(op, 32'h0000_6003, M_F3);   // lwu

    store_hit = inst_is(op, 32'h0000_0023, M_F3)   // sb
              | inst_is(op, 32'h0000_1023, M_F3)   // sh
              | inst_is(op, 32'h0000_2023, M_F3);  // sw

    jump_hit = inst_is(op, 32'h0000_006f, M_OP)    // jal
             | inst_is(op, 32'h0000_0067, M_F3);   // jalr

    bcc_hit = inst_is(op, 32'h0000_0063, M_F3)     // beq
            | inst_is(op, 32'h0000_1063, M_F3)     // bne
            | inst_is(op, 32'h0000_4063, M_F3)     // blt
            | inst_is(op, 32'h0000_5063, M_F3)     // bge
            | inst_is(op, 32'h0000_6063, M_F3)     // bltu
            | inst_is(op, 32'h0000_7063, M_F3);    // bgeu

    // funct3[2] splits the M group: 0..3 multiply, 4..7 divide/remainder.
    mul_hit = en_md & inst_is(op, 32'h0200_0033, M_MD);
    div_hit = en_md & inst_is(op, 32'h0200_4033, M_MD);

    csr_rw_hit = inst_is(op, 32'h0000_1073, M_F3)  // csrrw
               | inst_is(op, 32'h0000_2073, M_F3)  // csrrs
               | inst_is(op, 32'h0000_3073, M_F3)  // csrrc
               | inst_is(op, 32'h0000_5073, M_F3)  // csrrwi
               | inst_is(op, 32'h0000_6073, M_F3)  // csrrsi
               | inst_is(op, 32'h0000_7073, M_F3); // csrrci

    // System and fence ops serialise through the CSR unit. MISC-MEM funct3=2 (CBM) is
    // deliberately absent so it decodes as invalid.
    csr_sys_hit = inst_is(op, 32'h0000_0073, M_ALL) // ecall
                | inst_is(op, 32'h0010_0073, M_ALL) // ebreak
                | inst_is(op, 32'h3020_0073, M_ALL) // mret
                | inst_is(op, 32'h1050_0073, M_ALL) // wfi
                | inst_is(op, 32'h0000_000f, M_F3)  // fence
                | inst_is(op, 32'h0000_100f, M_F3); // fence.i

    // mule lives in the custom-0 major opcode with funct3=0.
    mule_hit = SUPPORT_MULE & en_md & inst_is(op, 32'h0000_000b, M_F3);

    any_hit = exec_hit | load_hit | store_hit | jump_hit | bcc_hit | mul_hit | div_hit
            | csr_rw_hit | csr_sys_hit | mule_hit;

    flags            = '0;
    flags[F_INVALID] = ~any_hit;
    flags[F_EXEC]    = exec_hit;
    flags[F_LSU]     = load_hit | store_hit;
    flags[F_BRANCH]  = jump_hit | bcc_hit;
    flags[F_MUL]     = mul_hit;
    flags[F_DIV]     = div_hit;
    flags[F_CSR]     = csr_rw_hit | csr_sys_hit | ~any_hit;
    flags[F_MULE]    = mule_hit;
    flags[F_RD]      = exec_hit | load_hit | jump_hit | mul_hit | div_hit | csr_rw_hit
                     | mule_hit;
    flags[F_FAULT]   = 1'b0;
    return flags;
  endfunction

  // Decode each lane and compute its compacted write slot relative to tail.
  always_comb begin
    w_push_cnt = '0;
    for (int k = 0; k < FETCH_LANES; k++) begin
      w_wr_idx[k]     = r_tail + PTR_W'(w_push_cnt);
      w_lane_pc[k]    = bus.fetch_pc_i + 32'(4 * k);
      w_lane_flags[k] = bus.fetch_fault_i[k] ? FAULT_FLAGS
                      : classify(bus.fetch_opcode_i[32*k +: 32], bus.enable_muldiv_i);
      if (bus.fetch_valid_i[k]) begin
        w_push_cnt = w_push_cnt + CNT_W'(1);
      end
    end
  end

  // Accept depends only on registered occupancy; pops never open space in the same cycle.
  always_comb begin
    w_accept   = (r_count <= CNT_W'(DEPTH - FETCH_LANES));
    w_push     = w_accept & (|bus.fetch_valid_i) & ~bus.flush_i;
    w_push_add = w_push ? w_push_cnt : '0;
    w_pop_req  = CMP_W'(bus.issue_pop_i);
    w_pop_cnt  = (w_pop_req > CMP_W'(r_count)) ? r_count : CNT_W'(w_pop_req);
  end

  // Pointer and occupancy update; flush wins over any same-cycle push or pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_pop_cnt);
      r_tail  <= r_tail + PTR_W'(w_push_add);
      r_count <= r_count + w_push_add - w_pop_cnt;
    end
  end

  // Entry storage is not reset; slots are only observed once occupied.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      for (int k = 0; k < FETCH_LANES; k++) begin
        if (bus.fetch_valid_i[k]) begin
          r_opcode[w_wr_idx[k]] <= bus.fetch_opcode_i[32*k +: 32];
          r_pc[w_wr_idx[k]]     <= w_lane_pc[k];
          r_flags[w_wr_idx[k]]  <= w_lane_flags[k];
        end
      end
    end
  end

  // Present the oldest ISSUE_LANES slots; validity comes from occupancy, not pointers.
  always_comb begin
    bus.fetch_accept_o = w_accept;
    bus.count_o        = r_count;
    bus.issue_valid_o  = '0;
    bus.issue_opcode_o = '0;
    bus.issue_pc_o     = '0;
    bus.issue_flags_o  = '0;
    for (int k = 0; k < ISSUE_LANES; k++) begin
      bus.issue_valid_o[k]        = (int'(r_count) > k);
      bus.issue_opcode_o[32*k +: 32] = r_opcode[r_head + PTR_W'(k)];
      bus.issue_pc_o[32*k +: 32]     = r_pc[r_head + PTR_W'(k)];
      bus.issue_flags_o[10*k +: 10]  = r_flags[r_head + PTR_W'(k)];
    end
  end
endmodule

// File: tb/tb_biriscv_decode_queue.sv
// Self-checking bench for biriscv_decode_queue: directed scenarios plus a randomized phase
// compared against a queue-based reference model that decodes by instruction fields.
module tb_biriscv_decode_queue;
  localparam int unsigned FL           = 2;
  localparam int unsigned IL           = 2;
  localparam int unsigned DEPTH        = 8;
  localparam bit          SUPPORT_MULE = 1'b1;
  localparam int unsigned TMPL_N       = 29;

  localparam logic [31:0] TMPL [TMPL_N] = '{
    32'h0000_0013, 32'h0000_1013, 32'h4000_5013, 32'h0000_0037, 32'h0000_0017,
    32'h4000_0033, 32'h4000_5033, 32'h0000_2003, 32'h0000_6003, 32'h0000_2023,
    32'h0000_006f, 32'h0000_0067, 32'h0000_7063, 32'h0200_0033, 32'h0200_3033,
    32'h0200_4033, 32'h0200_7033, 32'h0000_0073, 32'h0010_0073, 32'h3020_0073,
    32'h1050_0073, 32'h0000_1073, 32'h0000_7073, 32'h0000_000f, 32'h0000_100f,
    32'h0000_200f, 32'h0000_000b, 32'h2000_0033, 32'h0000_3003
  };

  typedef struct packed {
    logic [31:0] op;
    logic [31:0] pc;
    logic [9:0]  flags;
  } entry_t;

  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  int     n_checks = 0;
  int     n_fail   = 0;
  entry_t model_q[$];

  always #5 clk = ~clk;

  biriscv_decode_queue_if #(.FETCH_LANES(FL), .ISSUE_LANES(IL), .DEPTH(DEPTH)) bus ();

  biriscv_decode_queue #(
    .FETCH_LANES (FL),
    .ISSUE_LANES (IL),
    .DEPTH       (DEPTH),
    .SUPPORT_MULE(SUPPORT_MULE)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference classification from instruction fields.
  function automatic logic [9:0] ref_flags(input logic [31:0] op, input logic en,
                                           input logic flt);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    int         cls;
    bit         rd;
    logic [9:0] f;
    opc = op[6:0];
    f3  = op[14:12];
    f7  = op[31:25];
    cls = 0;
    rd  = 1'b0;
    if (flt) return 10'h240;
    case (opc)
      7'h13: begin
        if ((f3 == 3'd1 && f7 == 7'h00) || (f3 == 3'd5 && (f7 == 7'h00 || f7 == 7'h20)) ||
            (f3 != 3'd1 && f3 != 3'd5)) begin
          cls = 1; rd = 1'b1;
        end
      end
      7'h37, 7'h17: begin cls = 1; rd = 1'b1; end
      7'h33: begin
        if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
          cls = 1; rd = 1'b1;
        end else if (f7 == 7'h01 && en) begin
          cls = (f3 < 3'd4) ? 4 : 5; rd = 1'b1;
        end
      end
      7'h03: if (f3 != 3'd3 && f3 != 3'd7) begin cls = 2; rd = 1'b1; end
      7'h23: if (f3 <= 3'd2) cls = 2;
      7'h6f: begin cls = 3; rd = 1'b1; end
      7'h67: if (f3 == 3'd0) begin cls = 3; rd = 1'b1; end
      7'h63: if (f3 != 3'd2 && f3 != 3'd3) cls = 3;
      7'h73: begin
        if (f3 != 3'd0 && f3 != 3'd4) begin
          cls = 6; rd = 1'b1;
        end else if (op == 32'h0000_0073 || op == 32'h0010_0073 || op == 32'h3020_0073 ||
                     op == 32'h1050_0073) begin
          cls = 6;
        end
      end
      7'h0f: if (f3 <= 3'd1) cls = 6;
      7'h0b: if (f3 == 3'd0 && en && SUPPORT_MULE) begin cls = 7; rd = 1'b1; end
      default: cls = 0;
    endcase
    if (cls == 0) return 10'h041;
    f      = '0;
    f[cls] = 1'b1;
    f[8]   = rd;
    return f;
  endfunction

  function automatic logic [31:0] rand_op();
    int unsigned sel;
    logic [31:0] op;
    sel = $urandom_range(TMPL_N, 0);
    if (sel == TMPL_N) return $urandom;
    op = TMPL[sel];
    if ($urandom_range(1, 0) == 1) op = op | ($urandom & 32'h01ff_8f80);
    return op;
  endfunction

  // Apply one cycle of the current inputs to the reference queue.
  task automatic model_step();
    int  pop;
    bit  acc;
    entry_t e;
    acc = (DEPTH - model_q.size()) >= FL;
    if (bus.flush_i) begin
      model_q.delete();
      return;
    end
    pop = int'(bus.issue_pop_i);
    if (pop > model_q.size()) pop = model_q.size();
    repeat (pop) void'(model_q.pop_front());
    if (acc) begin
      for (int k = 0; k < FL; k++) begin
        if (bus.fetch_valid_i[k]) begin
          e.op    = bus.fetch_opcode_i[32*k +: 32];
          e.pc    = bus.fetch_pc_i + 32'(4 * k);
          e.flags = ref_flags(e.op, bus.enable_muldiv_i, bus.fetch_fault_i[k]);
          model_q.push_back(e);
        end
      end
    end
  endtask

  task automatic compare_all();
    bit v;
    check_eq("count", 64'(bus.count_o), 64'(model_q.size()));
    check_eq("accept", 64'(bus.fetch_accept_o), 64'((DEPTH - model_q.size()) >= FL));
    for (int k = 0; k < IL; k++) begin
      v = k < model_q.size();
      check_eq($sformatf("valid%0d", k), 64'(bus.issue_valid_o[k]), 64'(v));
      if (v) begin
        check_eq($sformatf("op%0d", k), 64'(bus.issue_opcode_o[32*k +: 32]), 64'(model_q[k].op));
        check_eq($sformatf("pc%0d", k), 64'(bus.issue_pc_o[32*k +: 32]), 64'(model_q[k].pc));
        check_eq($sformatf("flags%0d", k), 64'(bus.issue_flags_o[10*k +: 10]),
                 64'(model_q[k].flags));
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input logic [FL-1:0] v, input logic [FL-1:0] f, input logic [31:0] op0,
                       input logic [31:0] op1, input logic [31:0] pc, input logic [1:0] pop,
                       input logic fl, input logic en);
    bus.fetch_valid_i   = v;
    bus.fetch_fault_i   = f;
    bus.fetch_opcode_i  = {op1, op0};
    bus.fetch_pc_i      = pc;
    bus.issue_pop_i     = pop;
    bus.flush_i         = fl;
    bus.enable_muldiv_i = en;
  endtask

  initial begin
    logic        en_r;
    logic [1:0]  fault_r;
    drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1);
    #12;
    check_eq("rst_count", 64'(bus.count_o), 64'd0);
    check_eq("rst_valid", 64'(bus.issue_valid_o), 64'd0);
    check_eq("rst_accept", 64'(bus.fetch_accept_o), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // ADDI + LW pair; nothing visible until the next cycle.
    drive(2'b11, 2'b00, 32'h0010_0093, 32'h0000_a103, 32'h8000_0000, 2'd0, 1'b0, 1'b1);
    #1;
    check_eq("same_cycle_valid", 64'(bus.issue_valid_o), 64'd0);
    tick();
    check_eq("t1_valid", 64'(bus.issue_valid_o), 64'h3);
    check_eq("t1_flags0", 64'(bus.issue_flags_o[9:0]), 64'h102);
    check_eq("t1_pc0", 64'(bus.issue_pc_o[31:0]), 64'h8000_0000);
    check_eq("t1_flags1", 64'(bus.issue_flags_o[19:10]), 64'h104);
    check_eq("t1_pc1", 64'(bus.issue_pc_o[63:32]), 64'h8000_0004);
    check_eq("t1_count", 64'(bus.count_o), 64'd2);
    drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b1);
    tick();
    drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b1);
    tick();

    // Sparse lane: only lane 1 holds BEQ.
    drive(2'b10, 2'b00, 32'hdead_beef, 32'h0020_8063, 32'h0000_1000, 2'd0, 1'b0, 1'b1);
    tick();
    check_eq("sparse_pc", 64'(bus.issue_pc_o[31:0]), 64'h0000_1004);
    check_eq("sparse_flags", 64'(bus.issue_flags_o[9:0]), 64'h008);
    check_eq("sparse_count", 64'(bus.count_o), 64'd1);
    drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 2'd1, 1'b0, 1'b1);
    tick();

    // MUL with M disabled then enabled; the first entry keeps its flags.
    drive(2'b01, 2'b00, 32'h0220_8033, 32'h0, 32'h0000_2000, 2'd0, 1'b0, 1'b0);
    tick();
    check_eq("mul_off", 64'(bus.issue_flags_o[9:0]), 64'h041);
    drive(2'b01, 2'b00, 32'h0220_8033, 32'h0, 32'h0000_2004, 2'd0, 1'b0, 1'b1);
    tick();
    check_eq("mul_frozen", 64'(bus.issue_flags_o[9:0]), 64'h041);
    check_eq("mul_on", 64'(bus.issue_flags_o[19:10]), 64'h110);
    drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b1);
    tick();

    // Faulting lane.
    drive(2'b01, 2'b01, 32'h0000_0013, 32'h0, 32'h0000_3000, 2'd0, 1'b0, 1'b1);
    tick();
    check_eq("fault_flags", 64'(bus.issue_flags_o[9:0]), 64'h240);
    check_eq("fault_op", 64'(bus.issue_opcode_o[31:0]), 64'h0000_0013);
    drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 2'd1, 1'b0, 1'b1);
    tick();

    // Fill: 1, 3, 5, 7 -> accept drops; a further push is refused.
    drive(2'b01, 2'b00, 32'h0000_0093, 32'h0, 32'h0000_4000, 2'd0, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 2'b00, 32'h0000_0093 | (32'(i) << 20), 32'h0000_0113 | (32'(i) << 20),
            32'h0000_4100 + 32'(i * 16), 2'd0, 1'b0, 1'b1);
      tick();
    end
    check_eq("full7_count", 64'(bus.count_o), 64'd7);
    check_eq("full7_accept", 64'(bus.fetch_accept_o), 64'd0);
    drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 2'd1, 1'b0, 1'b1);
    tick();
    drive(2'b11, 2'b00, 32'h0000_2003, 32'h0000_2023, 32'h0000_4200, 2'd0, 1'b0, 1'b1);
    tick();
    check_eq("full8_count", 64'(bus.count_o), 64'd8);
    check_eq("full8_accept", 64'(bus.fetch_accept_o), 64'd0);

    // Streaming pop 2 / push 2 across the pointer wrap.
    for (int i = 0; i < 10; i++) begin
      drive(2'b11, 2'b00, 32'h0000_0013 | (32'(i) << 20), 32'h0000_0033 | (32'(i) << 7),
            32'h0000_5000 + 32'(i * 8), 2'd2, 1'b0, 1'b1);
      tick();
    end
    check_eq("stream_count", 64'(bus.count_o), 64'd6);

    // Flush beats a simultaneous push and pop.
    drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 2'd1, 1'b0, 1'b1);
    tick();
    check_eq("pre_flush_count", 64'(bus.count_o), 64'd5);
    drive(2'b11, 2'b00, 32'h0000_0013, 32'h0000_0013, 32'h0000_6000, 2'd1, 1'b1, 1'b1);
    tick();
    check_eq("flush_count", 64'(bus.count_o), 64'd0);
    check_eq("flush_valid", 64'(bus.issue_valid_o), 64'd0);
    drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b1);
    tick();

    // Randomized traffic.
    en_r = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(15, 0) == 0) en_r = ~en_r;
      fault_r = ($urandom_range(7, 0) == 0) ? 2'($urandom) : 2'b00;
      drive(2'($urandom), fault_r, rand_op(), rand_op(), $urandom & 32'hffff_fffc,
            2'($urandom_range(2, 0)), $urandom_range(31, 0) == 0, en_r);
      tick();
    end

    // Asynchronous reset in the middle of a cycle.
    drive(2'b11, 2'b00, 32'h0000_0013, 32'h0000_0037, 32'h0000_7000, 2'd0, 1'b0, 1'b1);
    tick();
    drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("async_count", 64'(bus.count_o), 64'd0);
    check_eq("async_valid", 64'(bus.issue_valid_o), 64'd0);
    check_eq("async_accept", 64'(bus.fetch_accept_o), 64'd1);
    model_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b01, 2'b00, 32'h0000_006f, 32'h0, 32'h0000_8000, 2'd0, 1'b0, 1'b1);
    tick();
    check_eq("post_rst_flags", 64'(bus.issue_flags_o[9:0]), 64'h108);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/biriscv_decode_queue.md
Name: biriscv_decode_queue

Overview:
- Parametrised multi-lane decode stage between fetch and issue.
- Each cycle it accepts up to FETCH_LANES fetched instructions and classifies each one: invalid, exec, lsu, branch, mul, div, csr, mule, rd_valid and fault.
- Classified entries are stored in a circular queue of DEPTH entries, so fetch and issue are decoupled.
- Issue sees the oldest ISSUE_LANES entries and retires 0..ISSUE_LANES of them per cycle.

Parameters:
- FETCH_LANES, 2, instructions presented per fetch beat (1..4).
- ISSUE_LANES, 2, entries exposed to issue per cycle (1..4).
- DEPTH, 8, queue entries; power of 2, at least 2*FETCH_LANES.
- SUPPORT_MULE, 1, when 0 the mule class is never decoded and MULE opcodes are invalid.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  discard all queued entries (branch mispredict / exception)
- enable_muldiv_i  in  1  M-extension and mule enable; sampled at push
- fetch_valid_i  in  FETCH_LANES  per-lane valid
- fetch_fault_i  in  FETCH_LANES  per-lane fetch fault
- fetch_opcode_i  in  32*FETCH_LANES  lane k at bits [32k+31:32k]
- fetch_pc_i  in  32  PC of lane 0; lane k PC = fetch_pc_i + 4k
- fetch_accept_o  out  1  beat accepted this cycle when any fetch_valid_i bit is set
- issue_valid_o  out  ISSUE_LANES  bit k set if queue slot head+k is occupied
- issue_opcode_o  out  32*ISSUE_LANES  opcode of slot head+k
- issue_pc_o  out  32*ISSUE_LANES  PC of slot head+k
- issue_flags_o  out  10*ISSUE_LANES  flags of slot head+k
- issue_pop_i  in  $clog2(ISSUE_LANES+1)  number of entries retired this cycle
- count_o  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (rst_ni low, asynchronous):
  - head, tail and count clear to 0.
  - All issue_valid_o bits are 0 and fetch_accept_o is 1.
  - Entry storage need not be reset; the opcode, pc and flags outputs of invalid slots are don't-care.
- Flags bit order: [0]invalid [1]exec [2]lsu [3]branch [4]mul [5]div [6]csr [7]mule [8]rd_valid [9]fault.
- Classification:
  - Uses the INST_*/INST_*_MASK definitions in biriscv_defs.v.
  - mul, div and mule are qualified by enable_muldiv_i; mule is additionally qualified by SUPPORT_MULE.
  - invalid = no recognised pattern matches; csr is forced to 1 when invalid.
  - The CBM opcode is treated as invalid.
  - Fault lane: flags = fault|csr only (all other bits 0); opcode and PC are stored unchanged.
- Accept: fetch_accept_o = (DEPTH - count) >= FETCH_LANES, computed from registered count only. Pops in the same cycle do not increase acceptance (no combinational pop-to-accept path).
- Push (fetch_accept_o and any valid lane):
  - Valid lanes are compacted in ascending lane order into tail, tail+1, ...
  - Invalid lanes are skipped.
  - tail advances by popcount(fetch_valid_i), modulo DEPTH.
- Latency: a pushed entry appears on the issue outputs the cycle after the push, never in the same cycle.
- Pop:
  - head advances by min(issue_pop_i, count) modulo DEPTH; a pop beyond occupancy is clamped, never wraps count negative.
  - Pops are taken in order only.
- Simultaneous push and pop: count_next = count + pushed - popped.
- Full: count == DEPTH gives fetch_accept_o = 0. Pointer wrap must be handled with count, not pointer compare.
- Empty: all issue_valid_o = 0; a pop while empty has no effect.
- Flush: synchronous.
  - Next cycle: head = tail = count = 0.
  - Flush overrides a same-cycle push and pop; the pushed beat is discarded even if fetch_accept_o was 1.
- enable_muldiv_i changing while entries are queued does not reclassify them; flags are frozen at push.

Test Plan:
- Reset then push lanes {ADDI 0x00100093, LW 0x0000A103} at PC 0x80000000, no pop.
  - Next cycle: issue_valid_o = 2'b11, lane0 flags exec|rd_valid = 0x102, PC 0x80000000.
  - Lane1 flags lsu|rd_valid = 0x104, PC 0x80000004, count_o = 2.
- Sparse valid, fetch_valid_i = 2'b10 with BEQ: stored in slot 0 with PC fetch_pc_i+4, flags = 0x008, count_o = 1.
- enable_muldiv_i = 0 with MUL 0x02208033: flags = invalid|csr = 0x041. Repeat with enable_muldiv_i = 1: flags = mul|rd_valid = 0x110.
- Fault lane (fetch_fault_i = 1, opcode 0x00000013): flags = 0x240.
- Fill to DEPTH=8 with no pops: fetch_accept_o drops when count_o = 7. Pop 2 per cycle while pushing 2 per cycle: count stays constant, order preserved across pointer wrap.
- With count_o = 5, assert flush_i together with push of 2 and issue_pop_i = 1: next cycle count_o = 0, all issue_valid_o = 0.
- Assert rst_ni low mid-cycle: count_o = 0 immediately.
